// File: rtl/key_sw_conditioner.sv
// Synchronises and debounces the active-low enter key and the 10-bit switch bank into clk_50M strobes.
// Optional auto-repeat of key_press while held: define KEY_AUTO_REPEAT_EN.
`timescale 1ns/1ps
module key_sw_conditioner #(
    parameter int DEB_CYCLES    = 1_000_000,
    parameter int CNT_W         = 25,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic       key_bar,
    input  logic [9:0] sw_raw,
    output logic       key_level,
    output logic       key_press,
    output logic       key_release,
    output logic [9:0] sw_clean,
    output logic       sw_change
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DEB_DOWN, HELD, DEB_UP} key_state_t;

    key_state_t       state, state_nxt;
    logic [CNT_W-1:0] kcnt, kcnt_nxt;
    logic             press_nxt, release_nxt, rep_hit;
    logic             key_meta_p0, key_sync_p1, key_s;
    logic [9:0]       sw_meta_p0, sw_sync_p1, sw_last;
    logic [CNT_W-1:0] scnt;

    // Stage p0/p1: two-flop synchronisers; the key is inverted on entry so reset reads as released
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            key_meta_p0 <= 1'b0;
            key_sync_p1 <= 1'b0;
            sw_meta_p0  <= '0;
            sw_sync_p1  <= '0;
        end else begin
            key_meta_p0 <= ~key_bar;
            key_sync_p1 <= key_meta_p0;
            sw_meta_p0  <= sw_raw;
            sw_sync_p1  <= sw_meta_p0;
        end
    end

    assign key_s = key_sync_p1;

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            kcnt        <= '0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state       <= state_nxt;
            kcnt        <= kcnt_nxt;
            key_press   <= press_nxt;
            key_release <= release_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        kcnt_nxt  = '0;
        case (state)
            IDLE:     if (key_s) state_nxt = DEB_DOWN;
            DEB_DOWN: begin
                if (!key_s)                state_nxt = IDLE;
                else if (kcnt == DEB_LAST) state_nxt = HELD;
                else                       kcnt_nxt  = kcnt + 1'b1;
            end
            HELD:     if (!key_s) state_nxt = DEB_UP;
            DEB_UP:   begin
                if (key_s)                 state_nxt = HELD;
                else if (kcnt == DEB_LAST) state_nxt = IDLE;
                else                       kcnt_nxt  = kcnt + 1'b1;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        key_level   = (state == HELD) || (state == DEB_UP);
        press_nxt   = ((state == DEB_DOWN) && key_s && (kcnt == DEB_LAST)) || rep_hit;
        release_nxt = (state == DEB_UP) && !key_s && (kcnt == DEB_LAST);
    end

`ifdef KEY_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST   = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [CNT_W-1:0] rcnt;

    // Reloading to DELAY-PERIOD after each hit spaces later strobes by REPEAT_PERIOD
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            rcnt <= '0;
        end else if (state == IDLE) begin
            rcnt <= '0;
        end else if ((state == HELD) && key_s) begin
            if (rcnt == REP_LAST) rcnt <= REP_RELOAD;
            else                  rcnt <= rcnt + 1'b1;
        end
    end

    assign rep_hit = (state == HELD) && key_s && (rcnt == REP_LAST);
`else
    // Repeat timing has no effect in this build; the term folds to zero
    assign rep_hit = 1'b0 & (REPEAT_DELAY != REPEAT_PERIOD);
`endif

    // Shared switch window: any bit moving restarts it, so a multi-bit change yields one strobe
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            sw_last   <= '0;
            scnt      <= '0;
            sw_clean  <= '0;
            sw_change <= 1'b0;
        end else begin
            sw_last   <= sw_sync_p1;
            sw_change <= 1'b0;
            if (sw_sync_p1 != sw_last) begin
                scnt <= '0;
            end else if (sw_sync_p1 != sw_clean) begin
                if (scnt == DEB_LAST) begin
                    sw_clean  <= sw_sync_p1;
                    sw_change <= 1'b1;
                    scnt      <= '0;
                end else begin
                    scnt <= scnt + 1'b1;
                end
            end else begin
                scnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_key_sw_conditioner.sv
// Directed bench for key_sw_conditioner with DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
`timescale 1ns/1ps
module tb_key_sw_conditioner;

    logic       clk_50M = 1'b0;
    logic       rst;
    logic       key_bar;
    logic [9:0] sw_raw;
    logic       key_level, key_press, key_release, sw_change;
    logic [9:0] sw_clean;

    int n_assert = 0;
    int n_fail   = 0;

    key_sw_conditioner #(
        .DEB_CYCLES   (4),
        .CNT_W        (8),
        .REPEAT_DELAY (20),
        .REPEAT_PERIOD(8)
    ) dut (
        .clk_50M    (clk_50M),
        .rst        (rst),
        .key_bar    (key_bar),
        .sw_raw     (sw_raw),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .sw_clean   (sw_clean),
        .sw_change  (sw_change)
    );

    always #10 clk_50M = ~clk_50M;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One active edge, then settle 1 ns so outputs are sampled away from the edge
    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    // Tick i (1-based) after the key goes down; HELD entry strobe at i=7
    function automatic logic press_exp(input int i);
`ifdef KEY_AUTO_REPEAT_EN
        return (i == 7) || (i >= 27 && ((i - 27) % 8) == 0);
`else
        return (i == 7);
`endif
    endfunction

    logic bounce_seq [14] = '{0,0,0,1,1,0,0,0,1,1,1,1,1,1};

    initial begin
        rst = 1'b1; key_bar = 1'b1; sw_raw = 10'h000;
        repeat (3) tick();
        check("rst_level",   key_level,   1'b0);
        check("rst_press",   key_press,   1'b0);
        check("rst_release", key_release, 1'b0);
        check("rst_sw",      sw_clean,    10'h000);
        check("rst_swchg",   sw_change,   1'b0);

        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("idle_press", key_press, 1'b0);
            check("idle_level", key_level, 1'b0);
        end

        key_bar = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check("press_strobe", key_press,   (i == 7));
            check("press_level",  key_level,   (i >= 7));
            check("press_norel",  key_release, 1'b0);
        end

        key_bar = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("rel_strobe",  key_release, (i == 7));
            check("rel_level",   key_level,   (i < 7));
            check("rel_nopress", key_press,   1'b0);
        end

        for (int i = 0; i < 14; i++) begin
            key_bar = bounce_seq[i];
            tick();
            check("bounce_press", key_press,   1'b0);
            check("bounce_rel",   key_release, 1'b0);
            check("bounce_level", key_level,   1'b0);
        end

        sw_raw = 10'h2A5; tick(); tick();
        sw_raw = 10'h2A4; tick();
        check("sw_bounce_chg", sw_change, 1'b0);
        tick();
        sw_raw = 10'h2A5;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("sw_change", sw_change, (i == 7));
            check("sw_clean",  sw_clean,  (i >= 7) ? 10'h2A5 : 10'h000);
        end

        sw_raw = 10'h3FF; repeat (3) tick();
        sw_raw = 10'h2A5;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("sw_glitch_chg",   sw_change, 1'b0);
            check("sw_glitch_clean", sw_clean,  10'h2A5);
        end

        key_bar = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        check("mrst_level", key_level,   1'b0);
        check("mrst_press", key_press,   1'b0);
        check("mrst_rel",   key_release, 1'b0);
        check("mrst_sw",    sw_clean,    10'h000);
        tick();
        check("mrst_press2", key_press, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 70; i++) begin
            tick();
            check("hold_press", key_press,   press_exp(i));
            check("hold_level", key_level,   (i >= 7));
            check("hold_rel",   key_release, 1'b0);
            check("post_rst_sw", sw_change,  (i == 7));
        end

        rst = 1'b1;
        #1;
        check("hrst_level", key_level, 1'b0);
        check("hrst_sw",    sw_clean,  10'h000);
        tick();
        rst = 1'b0; key_bar = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("hrst_press", key_press,   1'b0);
            check("hrst_rel",   key_release, 1'b0);
            check("hrst_lvl",   key_level,   1'b0);
            check("hrst_swchg", sw_change,   (i == 7));
        end
        check("hrst_swfinal", sw_clean, 10'h2A5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/key_sw_conditioner.md
# key_sw_conditioner

Input conditioning stage between the board's raw push-button/slide-switch pins and the front-panel control FSM. Synchronises and debounces the active-low enter key and the 10-bit switch bank. Emits single-cycle press/release strobes and a clean, glitch-free switch vector in the `clk_50M` domain. Lets the downstream FSM clock only on `clk_50M` and qualify transitions with `key_press`, instead of using the button as a clock.

## Interface
- `DEB_CYCLES`, 1_000_000: stable-input cycles required to accept a change (20 ms at 50 MHz); minimum 2.
- `CNT_W`, 25: counter width; must hold `max(DEB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)`.
- `REPEAT_DELAY`, 25_000_000: held cycles before the first auto-repeat strobe (500 ms).
- `REPEAT_PERIOD`, 5_000_000: cycles between subsequent auto-repeat strobes (100 ms).

Ports:
- `clk_50M`  in  1  system clock; one clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `key_bar`  in  1  raw enter button, active low, asynchronous to `clk_50M`.
- `sw_raw`  in  10  raw slide switches, asynchronous.
- `key_level`  out  1  debounced key state; 1 = pressed.
- `key_press`  out  1  one-cycle strobe on accepted press (and on auto-repeat).
- `key_release`  out  1  one-cycle strobe on accepted release.
- `sw_clean`  out  10  debounced switch vector.
- `sw_change`  out  1  one-cycle strobe when `sw_clean` updates.

## Operation
- **Synchronisers.** Two-flop synchroniser on `key_bar` and on each `sw_raw` bit. `key_s` = inverted `key_bar` after synchronisation.
- **Key FSM**, states IDLE, DEB_DOWN, HELD, DEB_UP, with counter `kcnt`:
  - IDLE: on `key_s`=1, go to DEB_DOWN with `kcnt`=0.
  - DEB_DOWN: on `key_s`=0, return to IDLE (no strobe). On `kcnt`==DEB_CYCLES-1 with `key_s`=1, go to HELD and pulse `key_press`. Otherwise increment `kcnt`.
  - HELD: on `key_s`=0, go to DEB_UP with `kcnt`=0.
  - DEB_UP: on `key_s`=1, return to HELD (no strobe; repeat counter not reset). On `kcnt`==DEB_CYCLES-1 with `key_s`=0, go to IDLE and pulse `key_release`. Otherwise increment `kcnt`.
  - `key_level` is 1 in HELD and DEB_UP, 0 in IDLE and DEB_DOWN.
- **Switch debounce.** Uses one shared counter `scnt` and register `sw_last`:
  - Each cycle, `sw_last` <= synchronised switches.
  - If synchronised switches ≠ `sw_last`, `scnt` <= 0.
  - Else if synchronised switches ≠ `sw_clean`: when `scnt`==DEB_CYCLES-1, load `sw_clean` and pulse `sw_change`; otherwise increment `scnt`.
  - Else `scnt` holds at 0.
  - Multiple bits changing within the window produce exactly one `sw_change`.
- **Counter saturation.** Counters never wrap; each saturates or clears as defined above.

## Timing
- **Reset values.** All outputs 0, FSM in IDLE, counters 0, synchronisers 0. With `key_bar` high after reset, the synchroniser output settles to released.
- **Key press latency.** Let edge 0 be the first edge sampling `key_bar` low, with the input held stable. `key_press` is high during the cycle after edge DEB_CYCLES+2. `key_level` rises on the same edge.
- **Key release latency.** Same as press latency, measured from the rising edge of `key_bar`.
- **Switch latency.** `sw_clean`/`sw_change` update DEB_CYCLES+2 edges after the edge sampling the new stable value.
- **Bounce.** A bounce shorter than DEB_CYCLES restarts debounce. It never produces a strobe.
- **Strobes.** Never asserted in consecutive cycles. `key_press` and `key_release` are never asserted together.
- **Mid-operation reset.** `rst` asserted mid-debounce or mid-hold returns everything to reset values immediately. No strobe is emitted on reset exit.
- **Post-reset switches.** Switches that are nonzero at reset release cause one `sw_change` after DEB_CYCLES+2 cycles.

## Configuration
- **`KEY_AUTO_REPEAT_EN` defined.**
  - In HELD, repeat counter `rcnt` counts from entry to HELD.
  - At `rcnt`==REPEAT_DELAY-1, `key_press` pulses; then it pulses every REPEAT_PERIOD cycles while in HELD.
  - `rcnt` is paused in DEB_UP.
  - `rcnt` is cleared in IDLE.
- **Not defined.** Exactly one `key_press` per accepted press. `rcnt` logic is absent.

## Test plan
Bench parameters: DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
- Reset, then drive `key_bar` low at edge 0 and hold → `key_press`=1 only in the cycle after edge 6, `key_level`=1 from then; no `key_release`.
- `key_bar` low for 3 cycles, high 2, low 3, then high → no strobes, `key_level` stays 0.
- Hold pressed, then release cleanly → exactly one `key_release`, 6 edges after `key_bar` rises; `key_level` falls on the same edge.
- `sw_raw` 0x000→0x2A5, bit 0 toggling for 2 cycles mid-window, then stable → one `sw_change`, `sw_clean`=0x2A5, 6 edges after the last change.
- Press held 60 cycles with KEY_AUTO_REPEAT_EN → `key_press` at HELD entry, +20, +28, +36…; without the macro → single `key_press`.
- Assert `rst` while in DEB_DOWN with `kcnt`=2 → all outputs 0 next cycle; a held key after release of `rst` produces `key_press` 6 edges later.
